wd_tty: RTL and testbench

Console output stage downstream of the microcoded CPU's Write Direct (WD) path. The CPU hands over 7-bit ASCII characters, taken from rr[r][25:31] on a WD to device address 0. This block buffers them in a small FIFO and serialises each one as an 8N1 asynchronous frame on a single `tx` line. It replaces simulation-only character printing with synthesizable output, and it back-pressures the CPU when the buffer is full.

---
 rtl/tty_pkg.sv | 16 +
 rtl/wd_tty_if.sv | 9 +
 rtl/char_fifo.sv | 54 +++++
 rtl/wd_tty.sv | 135 +++++++++++++
 tb/tb_wd_tty.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tty_pkg.sv
// Shared definitions for the WD console output stage: FSM encoding and
// serial frame geometry.
package tty_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tty_state_e;

    localparam int   FRAME_BITS = 10;
    localparam int   DATA_BITS  = 8;
    localparam logic LINE_IDLE  = 1'b1;

endpackage

// File: rtl/wd_tty_if.sv
// Character handshake between the CPU's WD path and the console stage.
interface wd_tty_if;
    logic       wd_valid;
    logic [0:6] wd_char;
    logic       wd_ready;

    modport master (output wd_valid, output wd_char, input  wd_ready);
    modport slave  (input  wd_valid, input  wd_char, output wd_ready);
endinterface

// File: rtl/char_fifo.sv
// Synchronous FIFO with a combinational head; pushes while full and pops
// while empty are ignored.
module char_fifo
    import tty_pkg::*;
#(
    parameter int WIDTH = 7,
    parameter int DEPTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wd_tty.sv
// WD console output: buffers 7-bit characters from the CPU and sends each
// as an 8N1 frame (start, 7 data bits LSB first, a zero 8th bit, stop).
module wd_tty
    import tty_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    wd_tty_if.slave                wd,
    output logic                   tx,
    output logic                   busy,
    output logic [0:$clog2(DEPTH)] fifo_count,
    output logic                   overflow
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST_CYC = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    tty_state_e           state, state_n;
    logic [CW-1:0]        cyc, cyc_n;
    logic [BW-1:0]        bitcnt, bitcnt_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 tx_n;
    logic                 pop, push, full, empty, bit_done;
    logic [6:0]           head, din;
    logic [$clog2(DEPTH):0] count;

    assign din         = wd.wd_char;
    assign push        = wd.wd_valid & ~full;
    assign wd.wd_ready = ~full;
    assign fifo_count  = count;
    assign busy        = (state != IDLE) | ~empty;
    assign bit_done    = (cyc == LAST_CYC);

    char_fifo #(.WIDTH(7), .DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cyc      <= '0;
            bitcnt   <= '0;
            shift    <= '0;
            tx       <= LINE_IDLE;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            cyc      <= cyc_n;
            bitcnt   <= bitcnt_n;
            shift    <= shift_n;
            tx       <= tx_n;
            overflow <= overflow | (wd.wd_valid & full);
        end
    end

    // The pop from STOP lets frames run back to back with no idle bit.
    always_comb begin
        state_n  = state;
        cyc_n    = cyc;
        bitcnt_n = bitcnt;
        shift_n  = shift;
        tx_n     = tx;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                tx_n = LINE_IDLE;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = {1'b0, head};
                    tx_n    = 1'b0;
                    cyc_n   = '0;
                    state_n = START;
                end
            end
            START: begin
                if (bit_done) begin
                    state_n  = DATA;
                    tx_n     = shift[0];
                    cyc_n    = '0;
                    bitcnt_n = '0;
                end else begin
                    cyc_n = cyc + 1'b1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cyc_n = '0;
                    if (bitcnt == LAST_BIT) begin
                        state_n = STOP;
                        tx_n    = LINE_IDLE;
                    end else begin
                        shift_n  = {1'b0, shift[DATA_BITS-1:1]};
                        tx_n     = shift[1];
                        bitcnt_n = bitcnt + 1'b1;
                    end
                end else begin
                    cyc_n = cyc + 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    cyc_n = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_n = {1'b0, head};
                        tx_n    = 1'b0;
                        state_n = START;
                    end else begin
                        tx_n    = LINE_IDLE;
                        state_n = IDLE;
                    end
                end else begin
                    cyc_n = cyc + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = LINE_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wd_tty.sv
// Bench for wd_tty: frame-level reference model checked every cycle, an
// independent line decoder, a frame table and directed corner sequences.
module tb_wd_tty;
    import tty_pkg::*;

    localparam int DEPTH = 4;
    localparam int CPB   = 4;
    localparam int FCYC  = FRAME_BITS * CPB;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   tx, busy, overflow;
    logic [0:$clog2(DEPTH)] fifo_count;

    wd_tty_if wd ();

    wd_tty #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clock      (clock),
        .reset      (reset),
        .wd         (wd),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: queue of waiting chars, cycles left in current frame.
    logic [6:0] mq[$];
    int         tcnt = 0;
    logic [6:0] cur = '0;
    logic       movf = 1'b0;

    // Line decoder working only from the tx pin.
    logic       rx_act = 1'b0;
    int         rx_ph = 0;
    logic [9:0] rx_bits = '0;
    logic [6:0] rxq[$];

    typedef struct {
        logic [6:0] ch;
        logic [9:0] frame;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] frame_of(input logic [6:0] c);
        return {1'b1, 1'b0, c, 1'b0};
    endfunction

    task automatic step(input logic v, input logic [6:0] c, input logic rst);
        logic       rdy, exp_tx;
        logic [9:0] f;
        wd.wd_valid = v;
        wd.wd_char  = c;
        reset       = rst;
        @(posedge clock);
        #1;
        if (rst) begin
            mq.delete();
            tcnt = 0;
            movf = 1'b0;
        end else begin
            rdy = (mq.size() != DEPTH);
            if (tcnt > 0) tcnt--;
            if (tcnt == 0 && mq.size() > 0) begin
                cur  = mq.pop_front();
                tcnt = FCYC;
            end
            if (v) begin
                if (rdy) mq.push_back(c);
                else     movf = 1'b1;
            end
        end
        f = frame_of(cur);
        exp_tx = (tcnt == 0) ? 1'b1 : f[(FCYC - tcnt) / CPB];
        chk("tx", tx, exp_tx);
        chk("busy", busy, (tcnt > 0) || (mq.size() > 0));
        chk("fifo_count", fifo_count, mq.size());
        chk("wd_ready", wd.wd_ready, mq.size() != DEPTH);
        chk("overflow", overflow, movf);
        if (rst) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (tx === 1'b0) begin
                rx_act = 1'b1;
                rx_ph  = 0;
            end
        end else begin
            rx_ph++;
        end
        if (rx_act) begin
            if (rx_ph % CPB == CPB / 2) rx_bits[rx_ph / CPB] = tx;
            if (rx_ph == FCYC - 1) begin
                chk("rx_start", rx_bits[0], 1'b0);
                chk("rx_bit8", rx_bits[8], 1'b0);
                chk("rx_stop", rx_bits[9], 1'b1);
                rxq.push_back(rx_bits[7:1]);
                rx_act = 1'b0;
            end
        end
    endtask

    task automatic drain();
        int n;
        for (n = 0; n < 5000 && (tcnt > 0 || mq.size() > 0 || rx_act); n++)
            step(1'b0, 7'h0, 1'b0);
        chk("drain_timeout", n < 5000, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [6:0] sent[$];
        logic [6:0] c;
        logic       v;
        int         guard;

        tbl[0] = '{ch: 7'h41, frame: 10'h282};
        tbl[1] = '{ch: 7'h00, frame: 10'h200};
        tbl[2] = '{ch: 7'h7F, frame: 10'h2FE};
        tbl[3] = '{ch: 7'h55, frame: 10'h2AA};
        tbl[4] = '{ch: 7'h48, frame: 10'h290};
        tbl[5] = '{ch: 7'h49, frame: 10'h292};

        wd.wd_valid = 1'b0;
        wd.wd_char  = '0;
        reset       = 1'b1;
        step(1'b0, 7'h0, 1'b1);
        step(1'b0, 7'h0, 1'b1);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", wd.wd_ready, 1'b1);
        chk("rst_overflow", overflow, 1'b0);

        // Idle line
        repeat (100) step(1'b0, 7'h0, 1'b0);
        chk("idle_tx", tx, 1'b1);
        chk("idle_busy", busy, 1'b0);
        chk("idle_ready", wd.wd_ready, 1'b1);

        // Frame table: bit-centre samples, length, busy release
        for (int i = 0; i < 6; i++) begin
            step(1'b1, tbl[i].ch, 1'b0);
            for (int p = 0; p < FCYC; p++) begin
                step(1'b0, 7'h0, 1'b0);
                if (p % CPB == CPB / 2)
                    chk($sformatf("frame%0d_bit%0d", i, p / CPB), tx, tbl[i].frame[p / CPB]);
            end
            chk("frame_busy_in_stop", busy, 1'b1);
            step(1'b0, 7'h0, 1'b0);
            chk("frame_busy_after", busy, 1'b0);
            chk("frame_rx_cnt", rxq.size(), i + 1);
            if (rxq.size() > 0) chk("frame_rx_char", rxq[rxq.size() - 1], tbl[i].ch);
        end

        // Back-to-back "HI"
        rxq.delete();
        step(1'b1, 7'h48, 1'b0);
        chk("hi_count0", fifo_count, 1);
        step(1'b1, 7'h49, 1'b0);
        chk("hi_count1", fifo_count, 1);
        chk("hi_start1", tx, 1'b0);
        for (int p = 0; p < FCYC - 1; p++) step(1'b0, 7'h0, 1'b0);
        chk("hi_stop1", tx, 1'b1);
        chk("hi_count2", fifo_count, 1);
        step(1'b0, 7'h0, 1'b0);
        chk("hi_start2", tx, 1'b0);
        chk("hi_count3", fifo_count, 0);
        chk("hi_busy", busy, 1'b1);
        for (int p = 0; p < FCYC - 1; p++) step(1'b0, 7'h0, 1'b0);
        chk("hi_busy_stop2", busy, 1'b1);
        step(1'b0, 7'h0, 1'b0);
        chk("hi_busy_end", busy, 1'b0);
        chk("hi_rx_cnt", rxq.size(), 2);
        if (rxq.size() == 2) begin
            chk("hi_rx0", rxq[0], 7'h48);
            chk("hi_rx1", rxq[1], 7'h49);
        end

        // Full and overflow: 'a'..'f' held valid
        rxq.delete();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 7'(7'h61 + i), 1'b0);
            if (i == 4) begin
                chk("ovf_ready_low", wd.wd_ready, 1'b0);
                chk("ovf_count_full", fifo_count, DEPTH);
                chk("ovf_not_yet", overflow, 1'b0);
            end
        end
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_count_kept", fifo_count, DEPTH);
        drain();
        chk("ovf_sticky", overflow, 1'b1);
        chk("ovf_rx_cnt", rxq.size(), 5);
        for (int i = 0; i < 5 && i < rxq.size(); i++)
            chk($sformatf("ovf_rx%0d", i), rxq[i], 7'(7'h61 + i));
        step(1'b0, 7'h0, 1'b1);
        chk("ovf_cleared", overflow, 1'b0);

        // Pointer wrap: 40 random chars respecting ready
        rxq.delete();
        guard = 0;
        while (sent.size() < 40 && guard < 20000) begin
            c = 7'($urandom);
            v = ($urandom_range(0, 3) != 0) && (mq.size() != DEPTH);
            if (v) sent.push_back(c);
            step(v, c, 1'b0);
            guard++;
        end
        chk("wrap_guard", guard < 20000, 1'b1);
        drain();
        chk("wrap_rx_cnt", rxq.size(), 40);
        for (int i = 0; i < 40 && i < rxq.size(); i++)
            chk($sformatf("wrap_rx%0d", i), rxq[i], sent[i]);
        chk("wrap_no_ovf", overflow, 1'b0);

        // Random soak including offers while full
        for (int n = 0; n < 400; n++)
            step($urandom_range(0, 1) == 1, 7'($urandom), 1'b0);
        drain();
        step(1'b0, 7'h0, 1'b1);

        // Reset at cycle 15 of a frame with two characters queued
        rxq.delete();
        step(1'b1, 7'h31, 1'b0);
        step(1'b1, 7'h32, 1'b0);
        step(1'b1, 7'h33, 1'b0);
        chk("mid_queued", fifo_count, 2);
        repeat (13) step(1'b0, 7'h0, 1'b0);
        step(1'b0, 7'h0, 1'b1);
        chk("mid_tx", tx, 1'b1);
        chk("mid_count", fifo_count, 0);
        chk("mid_busy", busy, 1'b0);
        repeat (100) step(1'b0, 7'h0, 1'b0);
        chk("mid_no_frame", rxq.size(), 0);
        chk("mid_tx_idle", tx, 1'b1);
        step(1'b1, 7'h5A, 1'b0);
        drain();
        chk("mid_rx_cnt", rxq.size(), 1);
        if (rxq.size() > 0) chk("mid_rx_char", rxq[0], 7'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
